fp16_normalizer: RTL and testbench

FP16_NORMALIZER -- requirements
Module: fp16_normalizer

---
 rtl/fp16_pkg.sv | 29 ++
 rtl/exp_step5.sv | 26 ++
 rtl/fp16_normalizer.sv | 157 +++++++++++++++
 tb/tb_fp16_normalizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 post-add normalizer.
//   EXP_W / FRAC_W : exponent and stored-fraction widths
//   MANT_W         : working mantissa width (carry, hidden, fraction)
//   EXP_MAX        : all-ones exponent (infinity / NaN encoding)
//   state_e        : normalizer FSM states
//   result_t       : normalized result fields presented downstream
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              ovf;
    logic              uf;
  } result_t;

endpackage

// File: rtl/exp_step5.sv
// Controlled exponent step: exp_o = exp_i + 1 (up=1) or exp_i - 1 (up=0)
// when en is high, otherwise exp_i unchanged. The caller guarantees the
// step never wraps.
//   en    : apply the step
//   up    : 1 = increment, 0 = decrement
//   exp_i : current exponent
//   exp_o : stepped exponent
module exp_step5
  import fp16_pkg::*;
(
  input  logic             en,
  input  logic             up,
  input  logic [EXP_W-1:0] exp_i,
  output logic [EXP_W-1:0] exp_o
);

  localparam logic [EXP_W-1:0] ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  always_comb begin
    exp_o = exp_i;
    if (en) begin
      exp_o = up ? (exp_i + ONE) : (exp_i - ONE);
    end
  end

endmodule

// File: rtl/fp16_normalizer.sv
// Normalizes the raw sum of an fp16 add/sub datapath, one bit per cycle.
// A captured operand is shifted right once on carry-out, or left until the
// hidden bit is set or the exponent bottoms out at the subnormal scale.
// The shifted-out bit is truncated.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (one operand in flight)
//   in_sign/exp/mant      : sign, biased exponent, raw 12-bit mantissa
//   out_valid / out_ready : result handshake; outputs hold while stalled
//   out_sign/exp/frac     : normalized fp16 fields
//   out_ovf / out_uf      : overflow to infinity / subnormal-or-zero result
module fp16_normalizer #(
  parameter int EXP_W  = fp16_pkg::EXP_W,
  parameter int FRAC_W = fp16_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_ovf,
  output logic              out_uf
);

  import fp16_pkg::*;

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                sign_q,  sign_d;
  logic [EXP_W-1:0]    exp_q,   exp_d;
  logic [FRAC_W+1:0]   mant_q,  mant_d;
  logic                pass_q,  pass_d;   // operand arrived as inf/NaN
  logic                ovf_q,   ovf_d;
  logic                uf_q,    uf_d;

  logic                step_en;
  logic                step_up;
  logic [EXP_W-1:0]    step_exp;
  result_t             res;

  // Step decode is kept apart from the next-state logic so the stepped
  // exponent never feeds back into its own enable.
  assign step_up = mant_q[FRAC_W+1];
  assign step_en = (state_q == NORM) && !pass_q && (mant_q != '0) &&
                   (mant_q[FRAC_W+1] || (!mant_q[FRAC_W] && exp_q != EXP_ONE));

  exp_step5 u_exp_step (
    .en    (step_en),
    .up    (step_up),
    .exp_i (exp_q),
    .exp_o (step_exp)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    pass_d  = pass_q;
    ovf_d   = ovf_q;
    uf_d    = uf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          // A zero exponent denotes subnormals, which share exponent 1's scale.
          exp_d   = (in_exp == '0) ? EXP_ONE : in_exp;
          mant_d  = in_mant;
          pass_d  = (in_exp == EXP_MAX);
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = NORM;
        end
      end

      NORM: begin
        if (pass_q) begin
          state_d = DONE;
        end else if (mant_q == '0) begin
          exp_d   = '0;
          uf_d    = 1'b1;
          state_d = DONE;
        end else if (mant_q[FRAC_W+1]) begin
          mant_d = mant_q >> 1;
          exp_d  = step_exp;
          if (step_exp == EXP_MAX) begin
            mant_d[FRAC_W-1:0] = '0;
            ovf_d              = 1'b1;
          end
          state_d = DONE;
        end else if (mant_q[FRAC_W]) begin
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          // Cannot shift further without going below the subnormal scale.
          exp_d   = '0;
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = step_exp;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      pass_q  <= 1'b0;
      ovf_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      pass_q  <= pass_d;
      ovf_q   <= ovf_d;
      uf_q    <= uf_d;
    end
  end

  assign res = '{sign: sign_q, exp: exp_q, frac: mant_q[FRAC_W-1:0],
                 ovf: ovf_q, uf: uf_q};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = res.sign;
  assign out_exp   = res.exp;
  assign out_frac  = res.frac;
  assign out_ovf   = res.ovf;
  assign out_uf    = res.uf;

endmodule

// File: tb/tb_fp16_normalizer.sv
// Scoreboard bench for fp16_normalizer: the driver pushes the reference
// model's expected result (fields, latency, requested stall) when an
// operand is captured; a negedge monitor pops and compares on each result.
module tb_fp16_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [11:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [9:0]  out_frac;
  logic        out_ovf;
  logic        out_uf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
    logic       ovf;
    logic       uf;
    int         lat;
    int         cap;
    int         stall;
  } exp_t;

  exp_t sb[$];

  fp16_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_ovf   (out_ovf),
    .out_uf    (out_uf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: works on the numeric value of the operand. Left
  // shifts needed = distance of the leading one from the hidden position,
  // limited by how far the exponent may fall before reaching 1.
  function automatic exp_t model(input logic s, input int e, input int m);
    exp_t r;
    int ee, p, need, avail;
    r.sign = s; r.ovf = 1'b0; r.uf = 1'b0; r.lat = 1; r.cap = 0; r.stall = 0;
    r.exp = 5'd0; r.frac = 10'd0;
    if (e == 31) begin
      r.exp  = 5'd31;
      r.frac = 10'(m & 'h3ff);
    end else begin
      ee = (e == 0) ? 1 : e;
      if (m == 0) begin
        r.uf = 1'b1;
      end else if (m >= 2048) begin
        if (ee + 1 == 31) begin
          r.exp = 5'd31;
          r.ovf = 1'b1;
        end else begin
          r.exp  = 5'(ee + 1);
          r.frac = 10'((m >> 1) & 'h3ff);
        end
      end else begin
        p = 0;
        for (int i = 0; i < 11; i++) if (((m >> i) & 1) == 1) p = i;
        need  = 10 - p;
        avail = ee - 1;
        if (need <= avail) begin
          r.exp  = 5'(ee - need);
          r.frac = 10'((m << need) & 'h3ff);
          r.lat  = 1 + need;
        end else begin
          r.frac = 10'((m << avail) & 'h3ff);
          r.uf   = 1'b1;
          r.lat  = 1 + avail;
        end
      end
    end
    return r;
  endfunction

  // Drive an operand and hold it until the DUT takes it.
  task automatic send(input logic s, input logic [4:0] e, input logic [11:0] m,
                      input int stall, input bit push);
    exp_t x;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      x = model(s, int'(e), int'(m));
      x.cap   = cyc + 1;
      x.stall = stall;
      if (push) sb.push_back(x);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: compares each result on its first valid cycle, then checks it
  // holds steady and in_ready stays low for as long as it is stalled.
  bit          seen = 1'b0;
  int          hold = 0;
  exp_t        cur;
  logic [17:0] snap;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen      = 1'b0;
      hold      = 0;
      out_ready = 1'b1;
    end else if (out_valid) begin
      check("in_ready_while_valid", 32'(in_ready), 32'd0);
      if (!seen) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(sb.size()), 32'd1);
        end else begin
          cur  = sb.pop_front();
          seen = 1'b1;
          check("out_sign", 32'(out_sign), 32'(cur.sign));
          check("out_exp",  32'(out_exp),  32'(cur.exp));
          check("out_frac", 32'(out_frac), 32'(cur.frac));
          check("out_ovf",  32'(out_ovf),  32'(cur.ovf));
          check("out_uf",   32'(out_uf),   32'(cur.uf));
          check("latency",  32'(cyc - cur.cap), 32'(cur.lat));
          hold = cur.stall;
          snap = {cur.sign, cur.exp, cur.frac, cur.ovf, cur.uf};
        end
      end else begin
        check("stall_stable", 32'({out_sign, out_exp, out_frac, out_ovf, out_uf}), 32'(snap));
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = 1'b1;
        seen      = 1'b0;
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fields", 32'({out_sign, out_exp, out_frac, out_ovf, out_uf}), 32'd0);
    rst_n = 1'b1;

    // Directed cases, including boundary exponents.
    send(1'b0, 5'd15, 12'h400, 0, 1'b1);   // already normalized
    send(1'b1, 5'd15, 12'h802, 0, 1'b1);   // carry: right shift, truncate
    send(1'b0, 5'd15, 12'h001, 0, 1'b1);   // ten left shifts
    send(1'b1, 5'd3,  12'h040, 0, 1'b1);   // underflow to subnormal
    send(1'b0, 5'd30, 12'h800, 0, 1'b1);   // overflow to infinity
    send(1'b1, 5'd31, 12'h2a5, 0, 1'b1);   // inf/NaN pass-through
    send(1'b1, 5'd9,  12'h000, 0, 1'b1);   // zero keeps sign
    send(1'b0, 5'd0,  12'h155, 0, 1'b1);   // subnormal input
    send(1'b0, 5'd1,  12'h400, 0, 1'b1);   // exp 1 already normalized
    // Stall in DONE for 5 cycles with the next operand waiting.
    send(1'b0, 5'd20, 12'h0c3, 5, 1'b1);
    send(1'b1, 5'd10, 12'h123, 0, 1'b1);
    idle(3);

    // Reset in the middle of a long normalization.
    send(1'b0, 5'd15, 12'h001, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_exp",   32'(out_exp),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 5'd12, 12'h0f0, 0, 1'b1);
    idle(15);

    // Randomized operands with random gaps and backpressure.
    for (int n = 0; n < 150; n++) begin
      logic [11:0] m;
      m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), m,
           int'($urandom_range(0, 2)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
    end
    idle(1);

    for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    check("drain_pending", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
